// File: rtl/key_search_pkg.sv
// key_search_pkg: shared state type, key width default, key type and round-robin one-hot pick
package key_search_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;
  localparam int KEY_WIDTH_DEF = 24;
  typedef logic [KEY_WIDTH_DEF-1:0] key_t;
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [7:0] g;
    logic [2:0] j;
    g = '0;
    for (int i = 0; i < 8; i++) begin
      j = 3'((int'(ptr) + i) % n);
      if (i < n && g == '0 && req[j]) g[j] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/key_search_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over req starting at an internal pointer, pointer moves past the winner on adv
module rr_arbiter
  import key_search_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant
);
  logic [2:0] ptr, idx;
  logic [7:0] pick;
  always_comb begin
    pick = rr_pick(8'(req), ptr, N);
    idx = '0;
    for (int i = 0; i < 8; i++) if (pick[i]) idx = 3'(i);
  end
  assign grant = pick[N-1:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (adv) ptr <= (int'(idx) == N - 1) ? '0 : idx + 3'd1;
endmodule

// File: rtl/key_search_scheduler.sv
// key_search_scheduler: dispatches consecutive candidate keys round-robin to RC4 cores, aborts on first hit, reports winner
module key_search_scheduler
  import key_search_pkg::*;
#(
  parameter int                   NUM_CORES = 4,
  parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [NUM_CORES-1:0] core_start,
  output logic [KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_found,
  output logic                 core_abort,
  output logic                 busy,
  output logic                 search_done,
  output logic                 key_found,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [KEY_WIDTH-1:0] current_key
);
  localparam logic [KEY_WIDTH:0] KEY_LIM = {1'b0, KEY_MAX};
  state_t state, state_n;
  logic [KEY_WIDTH:0] next_key, nk_n;
  logic [NUM_CORES-1:0] busy_vec, busy_n, done_v, found_v, grant;
  logic [KEY_WIDTH-1:0] key_reg [NUM_CORES];
  logic [KEY_WIDTH-1:0] fk_n, win_key;
  logic kf_n, sd_n, abort_n, disp;
  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (~busy_vec),
    .adv     (disp),
    .grant   (grant)
  );
  always_comb begin
    done_v = core_done & busy_vec;
    found_v = done_v & core_found;
    disp = state == RUN && next_key <= KEY_LIM && busy_vec != '1;
    core_start = disp ? grant : '0;
    core_key = disp ? next_key[KEY_WIDTH-1:0] : '0;
    win_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) if (found_v[i]) win_key = key_reg[i];
    state_n = state;
    nk_n = next_key;
    busy_n = busy_vec;
    fk_n = found_key;
    kf_n = key_found;
    sd_n = search_done;
    abort_n = 1'b0;
    if (state == RUN) begin
      busy_n = (busy_vec & ~done_v) | core_start;
      nk_n = next_key + (KEY_WIDTH+1)'(disp);
      if (found_v != '0) begin
        state_n = FOUND;
        busy_n = '0;
        fk_n = win_key;
        kf_n = 1'b1;
        sd_n = 1'b1;
        abort_n = 1'b1;
      end else if (nk_n > KEY_LIM && busy_n == '0) begin
        state_n = EXHAUSTED;
        sd_n = 1'b1;
      end
    end else if (start) begin
      state_n = RUN;
      nk_n = '0;
      busy_n = '0;
      fk_n = '0;
      kf_n = 1'b0;
      sd_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      next_key <= '0;
      busy_vec <= '0;
      found_key <= '0;
      key_found <= 1'b0;
      search_done <= 1'b0;
      core_abort <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) key_reg[i] <= '0;
    end else begin
      state <= state_n;
      next_key <= nk_n;
      busy_vec <= busy_n;
      found_key <= fk_n;
      key_found <= kf_n;
      search_done <= sd_n;
      core_abort <= abort_n;
      for (int i = 0; i < NUM_CORES; i++) if (core_start[i]) key_reg[i] <= next_key[KEY_WIDTH-1:0];
    end
  end
  assign busy = state == RUN;
  assign current_key = next_key[KEY_WIDTH-1:0];
endmodule

// File: doc/key_search_scheduler.md
Name: key_search_scheduler

Overview:
- Sequences a bank of NUM_CORES RC4 decrypt datapath cores through a brute-force key search.
- Hands out consecutive candidate keys from 0 to KEY_MAX to idle cores using round-robin order.
- Collects done/found results, aborts all cores on the first hit, and reports the winning key.
- Sits between the board top level (KEY/SW/LEDR/HEX) and the replicated datapath + s/d/e memory instances.

Parameters:
- NUM_CORES, 4, number of datapath cores scheduled (1..8).
- KEY_WIDTH, 24, width of secret_key bus per core.
- KEY_MAX, 24'h3FFFFF, last candidate key tried (inclusive); benches override with small values.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a search from key 0.
- core_start  out  NUM_CORES  one-hot, one-cycle pulse; the selected core samples core_key this cycle.
- core_key  out  KEY_WIDTH  broadcast candidate key, valid with core_start.
- core_done  in  NUM_CORES  per-core one-cycle pulse; the core finished its key.
- core_found  in  NUM_CORES  per-core result, qualified by core_done.
- core_abort  out  1  one-cycle pulse; all cores return to idle.
- busy  out  1  high while a search is in progress.
- search_done  out  1  level; the search ended (found or exhausted).
- key_found  out  1  level; valid with search_done.
- found_key  out  KEY_WIDTH  winning key; valid when key_found = 1.
- current_key  out  KEY_WIDTH  next key to be dispatched (for HEX display).

Behaviour:
Reset:
- All outputs are 0.
- State IDLE; next_key = 0; all core busy bits clear; round-robin pointer = 0.

States: IDLE, RUN, FOUND, EXHAUSTED.
- IDLE: wait for start.
- On start: clear key_found, search_done and found_key; set next_key = 0; enter RUN.

RUN, dispatch:
- Each cycle, if next_key <= KEY_MAX and some core is idle, dispatch to exactly one idle core.
- The core is chosen round-robin, starting at pointer.
- On dispatch: pulse core_start[i], drive core_key = next_key, record key_reg[i] = next_key, set busy[i].
- Then increment next_key and move pointer to i+1 mod NUM_CORES.
- At most one dispatch per cycle.
- A core whose core_done pulses in cycle t becomes eligible for dispatch at t+1, never at t.

RUN, completion:
- On core_done[i], clear busy[i].
- If core_found[i] = 1: latch found_key = key_reg[i], pulse core_abort in the next cycle, clear all busy bits, enter FOUND.
- If several cores pulse done with found in the same cycle, the lowest index wins.
- A found in the same cycle as a dispatch takes priority. That dispatch is still issued, and is cancelled by the abort.
- When next_key > KEY_MAX and no core is busy, enter EXHAUSTED.

FOUND:
- search_done = 1, key_found = 1, busy = 0.
- core_done pulses arriving after the abort are ignored.

EXHAUSTED:
- search_done = 1, key_found = 0.

Start handling:
- start in FOUND or EXHAUSTED restarts the search, following the IDLE start rule.
- start during RUN is ignored.

Key arithmetic:
- next_key is KEY_WIDTH+1 bits wide, so the increment past KEY_MAX = 2^KEY_WIDTH-1 cannot wrap.
- current_key shows the low KEY_WIDTH bits.

Latency:
- First core_start occurs in the cycle after start.
- search_done asserts 1 cycle after the deciding core_done (found), or 1 cycle after the last busy core clears (exhausted).

Reset mid-search:
- Asynchronous return to reset values.
- No core_abort is issued, because cores share reset.

Unknowns:
- core_done/core_found for a core that is not busy are ignored (spurious).

Decomposition:
- Package key_search_pkg holds:
  - the state enum typedef;
  - the KEY_WIDTH default;
  - a key_t typedef;
  - a function for a round-robin one-hot pick given a request mask and pointer.
- One sub-module, rr_arbiter (parameter N), supplies the idle-core selection and pointer update.
- Everything else is flat.

Test Plan (NUM_CORES=2, KEY_MAX=7, cores modelled with 3-cycle latency):
1. Reset, start; core model reports found only for key 5 -> core_start alternates cores 0,1,0,1... with keys 0,1,2,3,4,5; found_key=5, key_found=1, search_done=1, exactly one core_abort pulse.
2. No key matches -> all 8 keys 0..7 dispatched exactly once; EXHAUSTED; search_done=1, key_found=0, current_key=8 truncated to 0x000008.
3. Cores 0 and 1 pulse done+found in the same cycle holding keys 2 and 3 -> found_key=2 (core 0 wins).
4. start pulsed during RUN at key 3 -> ignored; key sequence continues unbroken; then start after FOUND -> flags clear, next core_key=0.
5. reset_n low while core 1 busy with key 4 -> all outputs 0 immediately (async), no core_start; after release, IDLE until start.
6. Spurious core_done[1] with core_found[1]=1 while core 1 idle -> no state change, no abort.
